// File: rtl/datapath_pkg.sv
// Shared constants for the register-file/ALU execute core.
// Holds the datapath widths and the ALU opcode encodings.
package datapath_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NREGS      = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALU_OP_W   = 4;

  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'b1001;
  localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/alu.sv
// Combinational ALU: wrap-around arithmetic, logic, signed compare and shifts.
// Unlisted opcodes produce zero.
module alu
  import datapath_pkg::*;
#(
  parameter int unsigned XLEN = datapath_pkg::XLEN
) (
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  input  logic [ALU_OP_W-1:0] alu_control,
  output logic [XLEN-1:0]     result,
  output logic                zero
);

  logic [4:0] shamt;
  logic       less;

  assign shamt = b[4:0];
  assign less  = ($signed(a) < $signed(b));

  always_comb begin
    result = '0;
    unique case (alu_control)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_XOR: result = a ^ b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = XLEN'(less);
      ALU_SLL: result = a << shamt;
      ALU_SRL: result = a >> shamt;
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/datapath.sv
// Single-cycle execute core: register file with combinational reads feeding the ALU,
// result written back on the rising clock edge; only the zero flag is exported.
module datapath
  import datapath_pkg::*;
#(
  parameter int unsigned XLEN  = datapath_pkg::XLEN,
  parameter int unsigned NREGS = datapath_pkg::NREGS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] read_reg_num1,
  input  logic [REG_ADDR_W-1:0] read_reg_num2,
  input  logic [REG_ADDR_W-1:0] write_reg,
  input  logic [ALU_OP_W-1:0]   alu_control,
  input  logic                  regwrite,
  output logic                  zero_flag
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

  // x0 and out-of-range addresses read as zero
  always_comb begin
    op_a = '0;
    op_b = '0;
    if ((read_reg_num1 != '0) && (32'(read_reg_num1) < NREGS)) op_a = regs_q[read_reg_num1];
    if ((read_reg_num2 != '0) && (32'(read_reg_num2) < NREGS)) op_b = regs_q[read_reg_num2];
  end

  alu #(.XLEN(XLEN)) u_alu (
    .a           (op_a),
    .b           (op_b),
    .alu_control (alu_control),
    .result      (alu_result),
    .zero        (alu_zero)
  );

  assign zero_flag = alu_zero;

  // Write-back; writes to x0 are dropped
  always_comb begin
    for (int k = 0; k < int'(NREGS); k++) regs_d[k] = regs_q[k];
    if (regwrite && (write_reg != '0) && (32'(write_reg) < NREGS)) begin
      regs_d[write_reg] = alu_result;
    end
  end

  // Reset loads each register with its own index
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < int'(NREGS); k++) regs_q[k] <= XLEN'(k);
    end else begin
      for (int k = 0; k < int'(NREGS); k++) regs_q[k] <= regs_d[k];
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: a register-array model predicts zero_flag every
// cycle, and hand-computed literal checks pin the model.
module tb_datapath;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] read_reg_num1 = '0;
  logic [4:0] read_reg_num2 = '0;
  logic [4:0] write_reg = '0;
  logic [3:0] alu_control = 4'b0010;
  logic       regwrite = 1'b0;
  logic       zero_flag;

  int tests = 0;
  int fails = 0;

  logic [31:0] m [32];

  datapath dut (
    .clock         (clock),
    .reset         (reset),
    .read_reg_num1 (read_reg_num1),
    .read_reg_num2 (read_reg_num2),
    .write_reg     (write_reg),
    .alu_control   (alu_control),
    .regwrite      (regwrite),
    .zero_flag     (zero_flag)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: return a << sh;
      4'b1001: return a >> sh;
      4'b1100: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_result();
    logic [31:0] a;
    logic [31:0] b;
    a = (read_reg_num1 == 0) ? 32'd0 : m[read_reg_num1];
    b = (read_reg_num2 == 0) ? 32'd0 : m[read_reg_num2];
    return model_alu(alu_control, a, b);
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: zero_flag=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural state: reset reloads indices, enabled writes to nonzero registers land on the edge
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 32; k++) m[k] = 32'(k);
    end else if (regwrite && write_reg != 0) begin
      m[write_reg] = model_result();
    end
  end

  always @(negedge clock) begin
    #1;
    check("cycle", zero_flag, model_result() == 32'd0);
  end

  task automatic apply(input logic [4:0] r1, input logic [4:0] r2, input logic [3:0] op,
                       input logic [4:0] wr, input logic we);
    @(posedge clock);
    #1;
    read_reg_num1 = r1;
    read_reg_num2 = r2;
    alu_control   = op;
    write_reg     = wr;
    regwrite      = we;
  endtask

  task automatic lit(input string name, input logic exp);
    #3;
    check(name, zero_flag, exp);
  endtask

  localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD = 4'b0010, XOR_ = 4'b0011,
                         SUB = 4'b0110, SLT = 4'b0111, SLL = 4'b1000, SRL = 4'b1001,
                         NOR_ = 4'b1100, BAD = 4'b1111;

  initial begin
    #20 reset = 1'b1;
    apply(0, 0, ADD, 0, 0);  lit("x0+x0", 1'b1);
    apply(1, 0, SUB, 0, 0);  lit("x1 reset", 1'b0);
    apply(31, 0, SUB, 0, 0); lit("x31 reset", 1'b0);
    // x5 = 1, x6 = 3
    apply(0, 1, ADD, 5, 1);  lit("x0+x1", 1'b0);
    apply(5, 1, SUB, 0, 0);  lit("x5==1", 1'b1);
    apply(1, 2, ADD, 6, 1);  lit("x1+x2", 1'b0);
    apply(6, 3, SUB, 0, 0);  lit("x6==3", 1'b1);
    // ALU ops on x7=7, x3=3, each stored then compared against a register holding the answer
    apply(7, 3, SUB, 10, 1); lit("sub", 1'b0);
    apply(10, 4, SUB, 0, 0); lit("sub==4", 1'b1);
    apply(7, 3, AND_, 11, 1);
    apply(11, 3, SUB, 0, 0); lit("and==3", 1'b1);
    apply(7, 3, OR_, 12, 1);
    apply(12, 7, SUB, 0, 0); lit("or==7", 1'b1);
    apply(7, 3, XOR_, 13, 1);
    apply(13, 4, SUB, 0, 0); lit("xor==4", 1'b1);
    apply(7, 3, SLT, 14, 1); lit("slt 7<3", 1'b1);
    apply(14, 0, ADD, 0, 0); lit("x14==0", 1'b1);
    apply(3, 7, SLT, 15, 1); lit("slt 3<7", 1'b0);
    apply(15, 1, SUB, 0, 0); lit("slt==1", 1'b1);
    apply(7, 3, NOR_, 16, 1); lit("nor", 1'b0);
    apply(16, 8, ADD, 0, 0); lit("nor+8 wraps", 1'b1);
    apply(7, 3, SLL, 17, 1); lit("sll", 1'b0);
    apply(17, 3, SRL, 18, 1); lit("56>>3", 1'b0);
    apply(18, 7, SUB, 0, 0); lit("sll==56", 1'b1);
    apply(7, 3, SRL, 0, 0);  lit("srl==0", 1'b1);
    apply(7, 3, BAD, 0, 0);  lit("code1111", 1'b1);
    // write to x0 discarded; regwrite=0 leaves x9 alone
    apply(4, 5, ADD, 0, 1);  lit("x4+x5", 1'b0);
    apply(0, 0, OR_, 0, 0);  lit("x0 still 0", 1'b1);
    apply(1, 8, ADD, 19, 1);
    apply(1, 2, ADD, 9, 0);
    apply(9, 19, SUB, 0, 0); lit("x9==9", 1'b1);
    // self-accumulate x1 -> 2, 4, 8
    apply(1, 1, ADD, 1, 1);  lit("acc1", 1'b0);
    apply(1, 2, SUB, 0, 0);  lit("x1==2", 1'b1);
    apply(1, 1, ADD, 1, 1);
    apply(1, 4, SUB, 0, 0);  lit("x1==4", 1'b1);
    apply(1, 1, ADD, 1, 1);
    apply(1, 8, SUB, 0, 0);  lit("x1==8", 1'b1);
    // mid-cycle reset restores x6 immediately and blocks the pending write
    apply(0, 0, AND_, 6, 1);
    apply(6, 0, ADD, 0, 0);  lit("x6==0", 1'b1);
    reset = 1'b0;
    #1 check("rst x6=6", zero_flag, 1'b0);
    read_reg_num1 = 0; read_reg_num2 = 0; alu_control = AND_; write_reg = 6; regwrite = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b1;
    read_reg_num1 = 6; alu_control = ADD; regwrite = 1'b0;
    #1 check("wr suppressed", zero_flag, 1'b0);
    // first write after release lands on the next edge
    apply(0, 0, AND_, 6, 1);
    apply(6, 0, ADD, 0, 0);  lit("post-rst wr", 1'b1);
    apply(0, 0, ADD, 0, 0);
    @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
